// File: rtl/i2c_write_sequencer.sv
// Write-only I2C transaction sequencer: generates START/STOP itself and hands
// the address byte and each data byte to the TX byte controller.
module i2c_write_sequencer (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_tick,
   input  logic       i_start,
   input  logic [6:0] i_addr,
   input  logic [7:0] i_len,
   input  logic [7:0] i_wr_data,
   input  logic       i_wr_valid,
   output logic       o_wr_ready,
   input  logic       i_scl,
   output logic       o_tx_start,
   output logic [7:0] o_tx_data,
   input  logic       i_tx_done,
   input  logic       i_tx_error,
   output logic       o_seq_sda,
   output logic       o_seq_scl,
   output logic       o_line_sel,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_nack,
   output logic [7:0] o_bytes_sent
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_ADDR,
      S_DATA_WAIT,
      S_DATA,
      S_STOP,
      S_DONE
   } state_t;

   state_t     state, state_d;
   logic [1:0] step, step_d;
   logic [6:0] addr_q, addr_d;
   logic [7:0] remaining, remaining_d;
   logic       nack_q, nack_d;
   logic       sda_q, sda_d;
   logic       scl_q, scl_d;
   logic       tx_start_q, tx_start_d;
   logic [7:0] tx_data_q, tx_data_d;
   logic [7:0] sent_q, sent_d;

   // NOTE: every register updates with <= so all of them see the pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= S_IDLE;
         step       <= 2'd0;
         addr_q     <= 7'd0;
         remaining  <= 8'd0;
         nack_q     <= 1'b0;
         sda_q      <= 1'b1;
         scl_q      <= 1'b1;
         tx_start_q <= 1'b0;
         tx_data_q  <= 8'd0;
         sent_q     <= 8'd0;
      end else begin
         state      <= state_d;
         step       <= step_d;
         addr_q     <= addr_d;
         remaining  <= remaining_d;
         nack_q     <= nack_d;
         sda_q      <= sda_d;
         scl_q      <= scl_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         sent_q     <= sent_d;
      end
   end

   // NOTE: every variable gets its default before the case so no path can infer a latch.
   always_comb begin
      state_d     = state;
      step_d      = step;
      addr_d      = addr_q;
      remaining_d = remaining;
      nack_d      = nack_q;
      sda_d       = sda_q;
      scl_d       = scl_q;
      tx_start_d  = 1'b0;
      tx_data_d   = tx_data_q;
      sent_d      = sent_q;

      case (state)
         S_IDLE: begin
            sda_d  = 1'b1;
            scl_d  = 1'b1;
            step_d = 2'd0;
            if (i_start) begin
               addr_d      = i_addr;
               remaining_d = i_len;
               sent_d      = 8'd0;
               nack_d      = 1'b0;
               state_d     = S_START;
            end
         end

         S_START: begin
            if (i_tick) begin
               case (step)
                  2'd0: begin
                     sda_d  = 1'b1;
                     scl_d  = 1'b1;
                     step_d = 2'd1;
                  end
                  // A slave stretching SCL low keeps us here.
                  2'd1: if (i_scl) step_d = 2'd2;
                  2'd2: begin
                     sda_d  = 1'b0;
                     step_d = 2'd3;
                  end
                  default: begin
                     scl_d      = 1'b0;
                     step_d     = 2'd0;
                     tx_start_d = 1'b1;
                     tx_data_d  = {addr_q, 1'b0};
                     state_d    = S_ADDR;
                  end
               endcase
            end
         end

         S_ADDR: begin
            if (i_tx_error) begin
               nack_d  = 1'b1;
               step_d  = 2'd0;
               state_d = S_STOP;
            end else if (i_tx_done) begin
               step_d  = 2'd0;
               state_d = (remaining != 8'd0) ? S_DATA_WAIT : S_STOP;
            end
         end

         S_DATA_WAIT: begin
            if (i_wr_valid) begin
               tx_data_d   = i_wr_data;
               remaining_d = remaining - 8'd1;
               tx_start_d  = 1'b1;
               state_d     = S_DATA;
            end
         end

         S_DATA: begin
            if (i_tx_error) begin
               nack_d  = 1'b1;
               step_d  = 2'd0;
               state_d = S_STOP;
            end else if (i_tx_done) begin
               sent_d  = sent_q + 8'd1;
               step_d  = 2'd0;
               state_d = (remaining != 8'd0) ? S_DATA_WAIT : S_STOP;
            end
         end

         S_STOP: begin
            if (i_tick) begin
               case (step)
                  2'd0: begin
                     sda_d  = 1'b0;
                     scl_d  = 1'b0;
                     step_d = 2'd1;
                  end
                  2'd1: begin
                     scl_d  = 1'b1;
                     step_d = 2'd2;
                  end
                  2'd2: if (i_scl) step_d = 2'd3;
                  default: begin
                     sda_d   = 1'b1;
                     step_d  = 2'd0;
                     state_d = S_DONE;
                  end
               endcase
            end
         end

         S_DONE: state_d = S_IDLE;

         default: state_d = S_IDLE;
      endcase
   end

   // The byte controller owns the lines only while a byte is in flight or pending.
   assign o_line_sel   = !(state == S_ADDR || state == S_DATA_WAIT || state == S_DATA);
   assign o_wr_ready   = (state == S_DATA_WAIT);
   assign o_busy       = (state != S_IDLE);
   assign o_done       = (state == S_DONE);
   assign o_nack       = (state == S_DONE) && nack_q;
   assign o_seq_sda    = sda_q;
   assign o_seq_scl    = scl_q;
   assign o_tx_start   = tx_start_q;
   assign o_tx_data    = tx_data_q;
   assign o_bytes_sent = sent_q;

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Bench for i2c_write_sequencer: behavioural byte controller and data source,
// expected TX bytes queued at stimulus time and popped on each o_tx_start.
module tb_i2c_write_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       start = 1'b0;
   logic [6:0] addr = 7'd0;
   logic [7:0] len = 8'd0;
   logic [7:0] wr_data = 8'd0;
   logic       wr_valid = 1'b0;
   logic       wr_ready;
   logic       scl_line;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_done = 1'b0;
   logic       tx_error = 1'b0;
   logic       seq_sda, seq_scl, line_sel, busy, done, nack;
   logic [7:0] bytes_sent;
   logic       stretch = 1'b0;

   int total = 0;
   int bad = 0;
   int hs_cnt = 0;
   int rdy_seen = 0;
   int start_cnt = 0;
   int byte_idx = 0;
   int bc_idx = 0;
   int nack_at = -1;
   int tick_div = 0;
   logic       prev_sda = 1'b1;
   logic [7:0] exp_byte;
   logic [7:0] exp_tx[$];
   logic [7:0] feed[$];

   i2c_write_sequencer dut (
      .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_start(start),
      .i_addr(addr), .i_len(len), .i_wr_data(wr_data), .i_wr_valid(wr_valid),
      .o_wr_ready(wr_ready), .i_scl(scl_line), .o_tx_start(tx_start),
      .o_tx_data(tx_data), .i_tx_done(tx_done), .i_tx_error(tx_error),
      .o_seq_sda(seq_sda), .o_seq_scl(seq_scl), .o_line_sel(line_sel),
      .o_busy(busy), .o_done(done), .o_nack(nack), .o_bytes_sent(bytes_sent)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      tick_div <= (tick_div == 3) ? 0 : tick_div + 1;
      tick     <= (tick_div == 3);
   end

   // Bus: the byte controller idles SCL low; a slave may additionally hold it low.
   assign scl_line = line_sel ? (seq_scl & ~stretch) : 1'b0;

   // Data source: valid whenever bytes are queued, pops after each handshake.
   always begin
      @(negedge clk);
      if (!rst && wr_valid && wr_ready) begin
         hs_cnt++;
         @(posedge clk);
         #1;
         if (feed.size() != 0) void'(feed.pop_front());
      end
      wr_valid = (feed.size() != 0);
      if (feed.size() != 0) wr_data = feed[0];
   end

   // Byte controller: answers each tx_start three cycles later, NACKing byte nack_at.
   always begin
      @(negedge clk);
      if (!rst && tx_start) begin
         bc_idx = byte_idx;
         byte_idx++;
         repeat (3) @(negedge clk);
         if (!rst) begin
            if (bc_idx == nack_at) tx_error = 1'b1;
            else tx_done = 1'b1;
            @(negedge clk);
            tx_done  = 1'b0;
            tx_error = 1'b0;
         end
      end
   end

   // Monitor: TX byte scoreboard, ready observation, START edge detection.
   always @(negedge clk) begin
      if (!rst) begin
         if (tx_start) begin
            total++;
            if (exp_tx.size() == 0) begin
               bad++;
               $display("FAIL tx_byte: got %02h, no byte expected", tx_data);
            end else begin
               exp_byte = exp_tx.pop_front();
               if (tx_data !== exp_byte) begin
                  bad++;
                  $display("FAIL tx_byte: got %02h, expected %02h", tx_data, exp_byte);
               end
            end
         end
         if (wr_ready) rdy_seen++;
         if (line_sel && prev_sda === 1'b1 && seq_sda === 1'b0 && seq_scl === 1'b1)
            start_cnt++;
      end
      prev_sda = seq_sda;
   end

   task automatic wait_ticks(input int n, output bit ok);
      int seen = 0;
      ok = 1'b0;
      for (int i = 0; i < 100 * n; i++) begin
         @(negedge clk);
         if (tick) seen++;
         if (seen == n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_line(input logic val, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (line_sel === val) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Caller loads feed[] with the data bytes before calling.
   task automatic run_txn(input logic [6:0] a, input logic [7:0] n, input int nack_idx,
                          input bit st_start, input bit st_stop, input string name);
      int  exp_hs, exp_sent, n_data;
      bit  exp_nack, ok;
      exp_nack = (nack_idx >= 0);
      n_data   = exp_nack ? ((nack_idx == 0) ? 0 : nack_idx) : int'(n);
      exp_hs   = n_data;
      exp_sent = exp_nack ? ((nack_idx == 0) ? 0 : nack_idx - 1) : int'(n);
      exp_tx.push_back({a, 1'b0});
      for (int i = 0; i < n_data; i++) exp_tx.push_back(feed[i]);
      hs_cnt = 0; rdy_seen = 0; start_cnt = 0; byte_idx = 0;
      nack_at = nack_idx;
      stretch = st_start;

      @(negedge clk);
      addr = a; len = n; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL %s busy_after_start: got %b, expected 1", name, busy);
      end
      // A second request and changed inputs while busy must not disturb anything.
      addr = 7'h11; len = 8'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;

      if (st_start) begin
         wait_ticks(5, ok);
         total++;
         if (!ok || seq_sda !== 1'b1 || line_sel !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s start_stretch: sda=%b line_sel=%b busy=%b ok=%b, expected 1 1 1 1",
                     name, seq_sda, line_sel, busy, ok);
         end
         stretch = 1'b0;
      end

      if (st_stop) begin
         wait_line(1'b0, ok);
         if (ok) wait_line(1'b1, ok);
         stretch = 1'b1;
         if (ok) wait_ticks(6, ok);
         total++;
         if (!ok || seq_sda !== 1'b0 || seq_scl !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL %s stop_stretch: sda=%b scl=%b done=%b ok=%b, expected 0 1 0 1",
                     name, seq_sda, seq_scl, done, ok);
         end
         stretch = 1'b0;
      end

      ok = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s done_timeout: no o_done within bound", name);
      end else begin
         total++;
         if (nack !== exp_nack || bytes_sent !== 8'(exp_sent) || busy !== 1'b1) begin
            bad++;
            $display("FAIL %s result: nack=%b sent=%0d busy=%b, expected %b %0d 1",
                     name, nack, bytes_sent, busy, exp_nack, exp_sent);
         end
      end
      total++;
      if (hs_cnt != exp_hs || exp_tx.size() != 0 || start_cnt != 1) begin
         bad++;
         $display("FAIL %s sequence: handshakes=%0d left=%0d starts=%0d, expected %0d 0 1",
                  name, hs_cnt, exp_tx.size(), start_cnt, exp_hs);
      end
      if (exp_hs == 0) begin
         total++;
         if (rdy_seen != 0) begin
            bad++;
            $display("FAIL %s ready_seen: got %0d cycles, expected 0", name, rdy_seen);
         end
      end
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || line_sel !== 1'b1 || seq_sda !== 1'b1) begin
         bad++;
         $display("FAIL %s idle_after: busy=%b done=%b line_sel=%b sda=%b, expected 0 0 1 1",
                  name, busy, done, line_sel, seq_sda);
      end
      exp_tx.delete();
      feed.delete();
      nack_at = -1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if ({seq_sda, seq_scl, line_sel, wr_ready, tx_start, busy, done, nack} !== 8'b1110_0000 ||
          tx_data !== 8'h00 || bytes_sent !== 8'h00) begin
         bad++;
         $display("FAIL reset: sda,scl,sel,rdy,txs,busy,done,nack=%b tx_data=%02h sent=%0d, expected 11100000 00 0",
                  {seq_sda, seq_scl, line_sel, wr_ready, tx_start, busy, done, nack}, tx_data, bytes_sent);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      feed = '{8'hA5, 8'h3C};
      run_txn(7'h50, 8'd2, -1, 1'b0, 1'b0, "basic");
   endtask

   task automatic test_addr_nack();
      feed = '{8'h11, 8'h22};
      run_txn(7'h22, 8'd2, 0, 1'b0, 1'b0, "addr_nack");
   endtask

   task automatic test_data_nack();
      feed = '{8'h81, 8'h42, 8'hE7};
      run_txn(7'h2D, 8'd3, 2, 1'b0, 1'b0, "data_nack");
   endtask

   task automatic test_len_zero();
      run_txn(7'h50, 8'd0, -1, 1'b0, 1'b0, "len_zero");
   endtask

   task automatic test_stretch();
      feed = '{8'h5A};
      run_txn(7'h6B, 8'd1, -1, 1'b1, 1'b1, "stretch");
   endtask

   task automatic test_len_max();
      for (int i = 0; i < 255; i++) feed.push_back(8'(i) ^ 8'h5A);
      run_txn(7'h7F, 8'd255, -1, 1'b0, 1'b0, "len_max");
   endtask

   task automatic test_reset_mid();
      bit ok = 1'b0;
      exp_tx.push_back({7'h33, 1'b0});
      byte_idx = 0;
      @(negedge clk);
      addr = 7'h33; len = 8'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (wr_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      repeat (10) @(negedge clk);
      total++;
      if (!ok || wr_ready !== 1'b1 || line_sel !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid waiting: ok=%b ready=%b line_sel=%b, expected 1 1 0",
                  ok, wr_ready, line_sel);
      end
      rst = 1'b1;
      @(negedge clk);
      total++;
      if (line_sel !== 1'b1 || seq_sda !== 1'b1 || seq_scl !== 1'b1 || busy !== 1'b0 ||
          wr_ready !== 1'b0 || done !== 1'b0 || exp_tx.size() != 0) begin
         bad++;
         $display("FAIL rst_mid outputs: sel=%b sda=%b scl=%b busy=%b rdy=%b done=%b left=%0d, expected 1 1 1 0 0 0 0",
                  line_sel, seq_sda, seq_scl, busy, wr_ready, done, exp_tx.size());
      end
      rst = 1'b0;
      exp_tx.delete();
      @(negedge clk);
      feed = '{8'hC3};
      run_txn(7'h50, 8'd1, -1, 1'b0, 1'b0, "after_rst");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_addr_nack();
      test_data_nack();
      test_len_zero();
      test_stretch();
      test_len_max();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
